// File: rtl/instr_loader_if.sv
// instr_loader_if: instruction-description stream from a host into the loader
interface instr_loader_if;
  logic       valid;
  logic       ready;
  logic       last;
  logic [2:0] opcode;
  logic [2:0] a;
  logic [2:0] b;
  logic [1:0] sel;
  logic [1:0] gate;
  logic [2:0] c;
  logic [9:0] ram;
  modport master (output valid, last, opcode, a, b, sel, gate, c, ram, input ready);
  modport slave (input valid, last, opcode, a, b, sel, gate, c, ram, output ready);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: packs instruction fields into words, writes instruction memory, then releases the CPU
module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  instr_loader_if.slave     in_if,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [15:0]       imem_wdata_o,
  output logic              cpu_run_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              err_opcode_o,
  output logic              err_full_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q;
  logic in_ready_q, imem_we_q, cpu_run_q, load_done_q, err_opcode_q, err_full_q;
  logic [ADDR_W-1:0] imem_addr_q, ptr_q;
  logic [15:0] imem_wdata_q, pack_d;
  logic [ADDR_W:0] word_count_q;
  logic accept, legal, full;
  assign accept = in_if.valid && in_ready_q;
  assign legal = (in_if.opcode <= 3'b100);
  assign full = (ptr_q == ADDR_W'(MEM_DEPTH - 1));
  // field packing per opcode; illegal opcodes never reach the memory
  always_comb begin
    pack_d = in_if.opcode == 3'b001 ? {in_if.opcode, in_if.a, in_if.b, in_if.sel, in_if.gate, in_if.c} :
             in_if.opcode == 3'b010 ? {in_if.opcode, in_if.a, in_if.b, 7'b0} :
             in_if.opcode == 3'b011 ? {in_if.opcode, in_if.a, 7'b0, in_if.c} :
             in_if.opcode == 3'b100 ? {in_if.opcode, in_if.a, in_if.ram} : 16'h0000;
  end
  // load FSM: every output is registered; a legal accept writes one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      load_done_q  <= 1'b0;
      word_count_q <= '0;
      ptr_q        <= '0;
      err_opcode_q <= 1'b0;
      err_full_q   <= 1'b0;
    end else begin
      imem_we_q   <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (start_i) begin
            state_q      <= LOAD;
            in_ready_q   <= 1'b1;
            cpu_run_q    <= 1'b0;
            word_count_q <= '0;
            ptr_q        <= '0;
            err_opcode_q <= 1'b0;
            err_full_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (legal) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= ptr_q;
              imem_wdata_q <= pack_d;
              ptr_q        <= ptr_q + ADDR_W'(1);
              word_count_q <= word_count_q + (ADDR_W+1)'(1);
            end else begin
              err_opcode_q <= 1'b1;
            end
            if (legal && full && !in_if.last) err_full_q <= 1'b1;
            if (in_if.last || (legal && full)) begin
              state_q     <= RUN;
              in_ready_q  <= 1'b0;
              cpu_run_q   <= 1'b1;
              load_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_if.ready  = in_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_run_o    = cpu_run_q;
  assign load_done_o  = load_done_q;
  assign word_count_o = word_count_q;
  assign err_opcode_o = err_opcode_q;
  assign err_full_o   = err_full_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed vectors against hand-packed instruction words
module tb_instr_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic imem_we, cpu_run, load_done, err_opcode, err_full;
  logic [7:0] imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0] word_count;
  int n_cmp = 0, n_bad = 0;
  instr_loader_if bus ();
  instr_loader #(.ADDR_W(8), .MEM_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .in_if(bus.slave),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .cpu_run_o(cpu_run), .load_done_o(load_done), .word_count_o(word_count),
    .err_opcode_o(err_opcode), .err_full_o(err_full)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic l, input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [1:0] s, input logic [1:0] g,
                       input logic [2:0] c, input logic [9:0] r);
    bus.valid = v; bus.last = l; bus.opcode = op; bus.a = a; bus.b = b;
    bus.sel = s; bus.gate = g; bus.c = c; bus.ram = r;
  endtask
  task automatic idle_in();
    drive(1'b0, 1'b0, 3'b0, 3'b0, 3'b0, 2'b0, 2'b0, 3'b0, 10'h0);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_eop"}, 32'(err_opcode), 32'd0);
    check({tag, "_efull"}, 32'(err_full), 32'd0);
  endtask
  initial begin
    idle_in();
    step();
    step();
    check_reset("rst");
    rst = 1'b0;
    // single full-format word with last
    pulse_start();
    check("t1_ready", 32'(bus.ready), 32'd1);
    drive(1'b1, 1'b1, 3'b001, 3'b101, 3'b010, 2'b11, 2'b01, 3'b110, 10'h0);
    step();
    idle_in();
    check("t1_we", 32'(imem_we), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'd0);
    check("t1_wdata", 32'(imem_wdata), 32'h356E);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_run", 32'(cpu_run), 32'd1);
    check("t1_wc", 32'(word_count), 32'd1);
    check("t1_ready_off", 32'(bus.ready), 32'd0);
    step();
    check("t1_we_off", 32'(imem_we), 32'd0);
    check("t1_done_off", 32'(load_done), 32'd0);
    check("t1_run_hold", 32'(cpu_run), 32'd1);
    // restart from RUN, then back-to-back stream
    pulse_start();
    check("t2_run_drop", 32'(cpu_run), 32'd0);
    check("t2_ready", 32'(bus.ready), 32'd1);
    check("t2_wc_clr", 32'(word_count), 32'd0);
    drive(1'b1, 1'b0, 3'b010, 3'b111, 3'b001, 2'b00, 2'b00, 3'b000, 10'h0);
    step();
    check("t2_we0", 32'(imem_we), 32'd1);
    check("t2_addr0", 32'(imem_addr), 32'd0);
    check("t2_data0", 32'(imem_wdata), 32'h5C80);
    drive(1'b1, 1'b0, 3'b011, 3'b011, 3'b000, 2'b00, 2'b00, 3'b101, 10'h0);
    step();
    check("t2_we1", 32'(imem_we), 32'd1);
    check("t2_addr1", 32'(imem_addr), 32'd1);
    check("t2_data1", 32'(imem_wdata), 32'h6C05);
    check("t2_run_mid", 32'(cpu_run), 32'd0);
    drive(1'b1, 1'b1, 3'b100, 3'b010, 3'b000, 2'b00, 2'b00, 3'b000, 10'h2A5);
    step();
    idle_in();
    check("t2_we2", 32'(imem_we), 32'd1);
    check("t2_addr2", 32'(imem_addr), 32'd2);
    check("t2_data2", 32'(imem_wdata), 32'h8AA5);
    check("t2_run", 32'(cpu_run), 32'd1);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_wc", 32'(word_count), 32'd3);
    step();
    check("t2_we_off", 32'(imem_we), 32'd0);
    // illegal opcode between legal words with gaps; start during LOAD is ignored
    pulse_start();
    drive(1'b1, 1'b0, 3'b010, 3'b001, 3'b010, 2'b00, 2'b00, 3'b000, 10'h0);
    step();
    idle_in();
    check("t3_we0", 32'(imem_we), 32'd1);
    check("t3_data0", 32'(imem_wdata), 32'h4500);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_gap_we", 32'(imem_we), 32'd0);
    check("t3_start_ign", 32'(word_count), 32'd1);
    drive(1'b1, 1'b0, 3'b110, 3'b111, 3'b111, 2'b11, 2'b11, 3'b111, 10'h3FF);
    step();
    idle_in();
    check("t3_ill_we", 32'(imem_we), 32'd0);
    check("t3_eop", 32'(err_opcode), 32'd1);
    check("t3_ill_wc", 32'(word_count), 32'd1);
    step();
    drive(1'b1, 1'b1, 3'b011, 3'b100, 3'b000, 2'b00, 2'b00, 3'b011, 10'h0);
    step();
    idle_in();
    check("t3_we1", 32'(imem_we), 32'd1);
    check("t3_addr1", 32'(imem_addr), 32'd1);
    check("t3_data1", 32'(imem_wdata), 32'h7003);
    check("t3_wc", 32'(word_count), 32'd2);
    check("t3_run", 32'(cpu_run), 32'd1);
    // memory full: six words offered, four accepted
    pulse_start();
    check("t4_eop_clr", 32'(err_opcode), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 3'b100, 3'b000, 3'b000, 2'b00, 2'b00, 3'b000, 10'(i));
      step();
      if (i < 4) begin
        check($sformatf("t4_we%0d", i), 32'(imem_we), 32'd1);
        check($sformatf("t4_addr%0d", i), 32'(imem_addr), 32'(i));
        check($sformatf("t4_data%0d", i), 32'(imem_wdata), 32'h8000 + 32'(i));
      end else begin
        check($sformatf("t4_nowe%0d", i), 32'(imem_we), 32'd0);
      end
      if (i == 3) begin
        check("t4_ready_off", 32'(bus.ready), 32'd0);
        check("t4_efull", 32'(err_full), 32'd1);
        check("t4_run", 32'(cpu_run), 32'd1);
        check("t4_done", 32'(load_done), 32'd1);
      end
    end
    idle_in();
    check("t4_wc", 32'(word_count), 32'd4);
    // reset mid-load, then reload from address 0
    pulse_start();
    drive(1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 2'b00, 2'b00, 3'b000, 10'h0);
    step();
    drive(1'b1, 1'b0, 3'b010, 3'b111, 3'b001, 2'b00, 2'b00, 3'b000, 10'h0);
    step();
    idle_in();
    check("t5_wc_pre", 32'(word_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("t5");
    pulse_start();
    drive(1'b1, 1'b1, 3'b100, 3'b010, 3'b000, 2'b00, 2'b00, 3'b000, 10'h2A5);
    step();
    idle_in();
    check("t5_addr", 32'(imem_addr), 32'd0);
    check("t5_data", 32'(imem_wdata), 32'h8AA5);
    // only an illegal word with last still enters RUN
    step();
    pulse_start();
    drive(1'b1, 1'b1, 3'b111, 3'b000, 3'b000, 2'b00, 2'b00, 3'b000, 10'h0);
    step();
    idle_in();
    check("t6_we", 32'(imem_we), 32'd0);
    check("t6_run", 32'(cpu_run), 32'd1);
    check("t6_done", 32'(load_done), 32'd1);
    check("t6_wc", 32'(word_count), 32'd0);
    check("t6_eop", 32'(err_opcode), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the CPU instruction memory: packs field-level instruction descriptions into 16-bit instruction words.
- Writes them sequentially into instruction memory through a write port, then releases the pipelined CPU to run.
- Sits between a host or bench stimulus source and Data_path's instruction memory; the CPU fetch path is the reader of the same memory.
- Holds the CPU stalled for the whole load.

Parameters:
- ADDR_W, 8, instruction memory address width.
- MEM_DEPTH, 256, number of instruction words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  source has an instruction description.
- in_ready  output  1  loader accepts this cycle.
- in_last  input  1  marks the final instruction of the program.
- in_opcode  input  3  opcode [15:13].
- in_a  input  3  field [12:10] (REMEM or REGISTER).
- in_b  input  3  field [9:7] (REMEM or REGISTER).
- in_sel  input  2  field [6:5] (REMEM/REG select).
- in_gate  input  2  field [4:3] (gate select).
- in_c  input  3  field [2:0] (REMEM/REG).
- in_ram  input  10  RAM address [9:0].
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  16  packed instruction.
- cpu_run  output  1  1 = CPU may fetch/execute; 0 = CPU stalled.
- load_done  output  1  one-cycle pulse when loading completes.
- word_count  output  ADDR_W+1  words written this session.
- err_opcode  output  1  sticky: an illegal opcode was dropped.
- err_full  output  1  sticky: memory filled before in_last.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, load_done=0, word_count=0, err_opcode=0, err_full=0, FSM=IDLE.
- Reset mid-load aborts the session; words already written stay in memory.

FSM states: IDLE, LOAD, RUN.
- IDLE: start → LOAD; clear word_count, write pointer and both error flags.
- LOAD: in_ready=1. A transfer occurs when in_valid && in_ready.
- RUN: cpu_run=1, in_ready=0. start → LOAD; cpu_run drops in the same cycle the state leaves RUN.
- start while in LOAD is ignored.

Packing (combinational from inputs, registered on accept):
- 000: 16'h0000 (NOP).
- 001: {op, a, b, sel, gate, c}.
- 010: {op, a, b, 7'b0}.
- 011: {op, a, 7'b0, c}.
- 100: {op, a, ram}.
- 101–111: illegal. The transfer is accepted (handshake completes) but nothing is written; err_opcode is set; word_count and the pointer are unchanged.

Write timing (latency 1):
- A legal transfer at cycle N gives imem_we=1 at cycle N+1, with imem_addr = pointer and imem_wdata = packed word.
- The pointer and word_count increment at N+1.
- imem_we is 0 in every other cycle.

Completion:
- Accepting in_last (legal or illegal) at cycle N → RUN at N+1. load_done=1 for exactly N+1. cpu_run=1 from N+1.
- If a legal write lands at address MEM_DEPTH-1 without in_last: err_full=1, transition to RUN at the same timing as in_last. in_ready is already 0 in that write cycle.
- in_last with word_count=0 (e.g. only illegal words) still enters RUN.

Flow control:
- in_valid low in LOAD inserts gaps with no writes.
- Back-to-back transfers give one write per cycle.

Test Plan:
- Reset then start; send op=001, a=101, b=010, sel=11, gate=01, c=110 with in_last → imem_we at next cycle, addr 0, wdata 16'h356E; load_done pulse; cpu_run=1; word_count=1.
- Back-to-back stream of op010 (a=111, b=001), op011 (a=011, c=101), op100 (a=010, ram=10'h2A5, last) → writes 16'h5C80@0, 16'h6C05@1, 16'h8AA5@2 on consecutive cycles; cpu_run rises after the third write.
- Insert op=110 between two legal words with in_valid gaps → no write for it; err_opcode=1; legal words land at addr 0 and 1; word_count=2.
- MEM_DEPTH=4, send 6 words without in_last → 4 writes (addr 0–3); in_ready=0 after the 4th accept; err_full=1; RUN entered; words 5–6 never accepted.
- Assert rst two words into a load → all outputs return to reset values the next cycle; a new start writes again from addr 0.
- In RUN, pulse start → cpu_run=0 the same cycle; LOAD; word_count and error flags cleared.
